// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked data-memory controller for the MIPS MEM stage.
// Supports byte/halfword/word loads and stores with sign/zero extension on
// loads, alignment and address-range fault detection, and a synchronous-read
// RAM array held internally. One access completes every two cycles.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rst    - synchronous active-high reset
//   req    - access request, sampled while ready=1
//   we     - 1 = store, 0 = load
//   size   - 00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   uns    - load only: 1 = zero-extend, 0 = sign-extend
//   addr   - byte address
//   wdata  - store data, right-justified
//   ready  - 1 while idle; request accepted on req & ready
//   done   - one-cycle completion pulse
//   err    - valid with done: access faulted
//   rdata  - load result, valid with done, held until next done
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          range_fault;
    logic          align_fault;
    logic          fault;
    logic          accept;
    logic [3:0]    be;
    logic [31:0]   wword;

    // Access context captured at accept
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    lane_q;
    logic          fault_q;
    logic [31:0]   rd_word;
    logic [31:0]   load_ext;

    assign ready  = (state == IDLE);
    assign accept = req && ready;
    assign offset = addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign lane   = offset[1:0];

    always_comb begin
        // Addresses below BASE wrap to a huge offset and land here too
        range_fault = (64'(offset) >= 64'(DEPTH_WORDS) * 64'd4);
        align_fault = 1'b0;
        be          = 4'b0000;
        wword       = wdata;
        case (size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                align_fault = lane[0];
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wword       = {2{wdata[15:0]}};
            end
            2'b10: begin
                align_fault = (lane != 2'b00);
                be          = 4'b1111;
            end
            default: align_fault = 1'b1;
        endcase
        fault = range_fault || align_fault;
    end

    // RAM: written and read at the accept edge; contents never reset
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            if (we && !fault) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wword[8*i +: 8];
                    end
                end
            end
            rd_word <= mem[idx];
        end
    end

    always_comb begin
        logic [7:0]  bsel;
        logic [15:0] hsel;
        bsel = 8'h00;
        case (lane_q)
            2'd0:    bsel = rd_word[7:0];
            2'd1:    bsel = rd_word[15:8];
            2'd2:    bsel = rd_word[23:16];
            default: bsel = rd_word[31:24];
        endcase
        hsel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
            2'b01:   load_ext = uns_q ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        state   <= ACCESS;
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        lane_q  <= lane;
                        fault_q <= fault;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    err   <= fault_q;
                    if (!we_q) begin
                        rdata <= fault_q ? '0 : load_ext;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl. Each task drives
// one scenario and compares DUT outputs against hand-computed values.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;

    dmem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1001_0000)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .size  (size),
        .uns   (uns),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .done  (done),
        .err   (err),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One access from an IDLE cycle (#1 after an edge); returns done seen in
    // the ACCESS cycle (d1) and the following cycle (d2) plus outputs there.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic d1, output logic d2,
                             output logic [31:0] rd, output logic e);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        d1 = done;
        @(posedge clk); #1;
        d2 = done; rd = rdata; e = err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    endtask

    task automatic test_word;
        op_t ops[2];
        logic d1, d2, e;
        logic [31:0] rd;
        ops[0] = '{1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        ops[1] = '{1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0,        32'hDEAD_BEEF, 1'b0};
        foreach (ops[i]) begin
            do_access(ops[i].w, ops[i].sz, ops[i].u, ops[i].a, ops[i].d, d1, d2, rd, e);
            n_checks++; if (d1 !== 1'b0 || d2 !== 1'b1) begin n_errors++; $display("FAIL word_done[%0d]: got %b%b expected 01", i, d1, d2); end
            n_checks++; if (e !== ops[i].exp_err) begin n_errors++; $display("FAIL word_err[%0d]: got %b expected %b", i, e, ops[i].exp_err); end
            n_checks++; if (rd !== ops[i].exp_rd) begin n_errors++; $display("FAIL word_rdata[%0d]: got %h expected %h", i, rd, ops[i].exp_rd); end
        end
    endtask

    task automatic test_lanes;
        op_t ops[12];
        logic d1, d2, e;
        logic [31:0] rd;
        ops[0]  = '{1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        ops[1]  = '{1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0};
        ops[2]  = '{1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0,         32'h11A5_3344, 1'b0};
        ops[3]  = '{1'b0, 2'b00, 1'b0, 32'h1001_000A, 32'h0,         32'hFFFF_FFA5, 1'b0};
        ops[4]  = '{1'b0, 2'b00, 1'b1, 32'h1001_000A, 32'h0,         32'h0000_00A5, 1'b0};
        ops[5]  = '{1'b0, 2'b01, 1'b0, 32'h1001_0008, 32'h0,         32'h0000_3344, 1'b0};
        ops[6]  = '{1'b1, 2'b01, 1'b0, 32'h1001_0008, 32'h0000_8001, 32'h0000_3344, 1'b0};
        ops[7]  = '{1'b0, 2'b01, 1'b0, 32'h1001_0008, 32'h0,         32'hFFFF_8001, 1'b0};
        ops[8]  = '{1'b0, 2'b01, 1'b1, 32'h1001_000A, 32'h0,         32'h0000_11A5, 1'b0};
        ops[9]  = '{1'b0, 2'b00, 1'b0, 32'h1001_000B, 32'h0,         32'h0000_0011, 1'b0};
        ops[10] = '{1'b0, 2'b00, 1'b1, 32'h1001_0008, 32'h0,         32'h0000_0001, 1'b0};
        ops[11] = '{1'b0, 2'b00, 1'b0, 32'h1001_0009, 32'h0,         32'hFFFF_FF80, 1'b0};
        foreach (ops[i]) begin
            do_access(ops[i].w, ops[i].sz, ops[i].u, ops[i].a, ops[i].d, d1, d2, rd, e);
            n_checks++; if (d1 !== 1'b0 || d2 !== 1'b1) begin n_errors++; $display("FAIL lane_done[%0d]: got %b%b expected 01", i, d1, d2); end
            n_checks++; if (e !== ops[i].exp_err) begin n_errors++; $display("FAIL lane_err[%0d]: got %b expected %b", i, e, ops[i].exp_err); end
            n_checks++; if (rd !== ops[i].exp_rd) begin n_errors++; $display("FAIL lane_rdata[%0d]: got %h expected %h", i, rd, ops[i].exp_rd); end
        end
    endtask

    task automatic test_faults;
        op_t ops[16];
        logic d1, d2, e;
        logic [31:0] rd;
        ops[0]  = '{1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h0102_0304, 32'hFFFF_FF80, 1'b0};
        ops[1]  = '{1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0,         32'h0000_0000, 1'b1};
        ops[2]  = '{1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        ops[3]  = '{1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'h0102_0304, 1'b0};
        ops[4]  = '{1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        ops[5]  = '{1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'h0,         32'h0000_0000, 1'b1};
        ops[6]  = '{1'b1, 2'b10, 1'b0, 32'h1001_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        ops[7]  = '{1'b0, 2'b10, 1'b0, 32'h1001_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        ops[8]  = '{1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0,         32'h0000_0000, 1'b1};
        ops[9]  = '{1'b1, 2'b11, 1'b0, 32'h1001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        ops[10] = '{1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'h0102_0304, 1'b0};
        ops[11] = '{1'b1, 2'b01, 1'b0, 32'h1001_0003, 32'h0000_ABCD, 32'h0102_0304, 1'b1};
        ops[12] = '{1'b0, 2'b10, 1'b0, 32'h1001_0006, 32'h0,         32'h0000_0000, 1'b1};
        ops[13] = '{1'b1, 2'b00, 1'b0, 32'h1001_0003, 32'h0000_0077, 32'h0000_0000, 1'b0};
        ops[14] = '{1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'h7702_0304, 1'b0};
        ops[15] = '{1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0,         32'h0000_7702, 1'b0};
        foreach (ops[i]) begin
            do_access(ops[i].w, ops[i].sz, ops[i].u, ops[i].a, ops[i].d, d1, d2, rd, e);
            n_checks++; if (d1 !== 1'b0 || d2 !== 1'b1) begin n_errors++; $display("FAIL fault_done[%0d]: got %b%b expected 01", i, d1, d2); end
            n_checks++; if (e !== ops[i].exp_err) begin n_errors++; $display("FAIL fault_err[%0d]: got %b expected %b", i, e, ops[i].exp_err); end
            n_checks++; if (rd !== ops[i].exp_rd) begin n_errors++; $display("FAIL fault_rdata[%0d]: got %h expected %h", i, rd, ops[i].exp_rd); end
        end
    endtask

    task automatic test_back_to_back;
        op_t ops[4];
        int pulses = 0;
        ops[0] = '{1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'hAAAA_0001, 32'h0,         1'b0};
        ops[1] = '{1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0,         32'hAAAA_0001, 1'b0};
        ops[2] = '{1'b1, 2'b10, 1'b0, 32'h1001_0014, 32'h0BAD_F00D, 32'h0,         1'b0};
        ops[3] = '{1'b0, 2'b10, 1'b0, 32'h1001_0014, 32'h0,         32'h0BAD_F00D, 1'b0};
        req = 1'b1; we = ops[0].w; size = ops[0].sz; uns = ops[0].u; addr = ops[0].a; wdata = ops[0].d;
        // Edge 0 accepts op0; ops 1..3 are accepted at edges 2, 4, 6
        for (int k = 0; k <= 8; k++) begin
            logic exp_done;
            logic exp_ready;
            @(posedge clk); #1;
            exp_done  = (k % 2 == 1);
            exp_ready = (k % 2 == 1) || (k == 8);
            if (done === 1'b1) pulses++;
            n_checks++; if (done !== exp_done) begin n_errors++; $display("FAIL b2b_done[k=%0d]: got %b expected %b", k, done, exp_done); end
            n_checks++; if (ready !== exp_ready) begin n_errors++; $display("FAIL b2b_ready[k=%0d]: got %b expected %b", k, ready, exp_ready); end
            if (k == 3 || k == 7) begin
                n_checks++; if (rdata !== ops[k/2].exp_rd) begin n_errors++; $display("FAIL b2b_rdata[k=%0d]: got %h expected %h", k, rdata, ops[k/2].exp_rd); end
            end
            if (k == 0 || k == 2 || k == 4) begin
                we = ops[k/2+1].w; size = ops[k/2+1].sz; uns = ops[k/2+1].u;
                addr = ops[k/2+1].a; wdata = ops[k/2+1].d;
            end
            if (k == 6) req = 1'b0;
        end
        n_checks++; if (pulses != 4) begin n_errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    endtask

    task automatic test_reset_mid;
        logic d1, d2, e;
        logic [31:0] rd;
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h1001_0020; wdata = 32'h5555_5555;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done_a: got %b expected 0", done); end
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done_b: got %b expected 0", done); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL rstmid_rdata_rst: got %h expected 00000000", rdata); end
        do_access(1'b0, 2'b10, 1'b0, 32'h1001_0020, 32'h0, d1, d2, rd, e);
        n_checks++; if (d1 !== 1'b0 || d2 !== 1'b1) begin n_errors++; $display("FAIL rstmid_lw_done: got %b%b expected 01", d1, d2); end
        n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL rstmid_lw_err: got %b expected 0", e); end
        n_checks++; if (rd !== 32'h5555_5555) begin n_errors++; $display("FAIL rstmid_lw_rdata: got %h expected 55555555", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
